// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - fixed-priority D > I > PF memory-port arbiter with completion tag routing
// Optional grant/reject/throttle counters are enabled with `define ARB_STATS_EN.
module mem_req_arbiter #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        dcache_cmd,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic [DATA_W-1:0] dcache_data,
  input  logic              icache_req,
  input  logic [ADDR_W-1:0] icache_addr,
  input  logic              pf_req,
  input  logic [ADDR_W-1:0] pf_addr,
  input  logic [3:0]        mem2proc_response,
  input  logic [3:0]        mem2proc_tag,
  input  logic [DATA_W-1:0] mem2proc_data,
  output logic [1:0]        proc2mem_command,
  output logic [ADDR_W-1:0] proc2mem_addr,
  output logic [DATA_W-1:0] proc2mem_data,
  output logic [3:0]        dcache_resp_tag,
  output logic [3:0]        icache_resp_tag,
  output logic [3:0]        pf_resp_tag,
  output logic              dcache_done,
  output logic              icache_done,
  output logic              pf_done,
  output logic [3:0]        done_tag,
  output logic [DATA_W-1:0] done_data,
  output logic [3:0]        outstanding_cnt
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       stat_grant_d,
  output logic [15:0]       stat_grant_i,
  output logic [15:0]       stat_grant_pf,
  output logic [15:0]       stat_reject,
  output logic [15:0]       stat_throttle
`endif
);

  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;
  localparam logic [1:0] SRC_D     = 2'd0;
  localparam logic [1:0] SRC_I     = 2'd1;
  localparam logic [1:0] SRC_PF    = 2'd2;

  logic [15:0] valid_q;
  logic [1:0]  src_q [16];
  logic [3:0]  cnt_q;

  logic       under_limit;
  logic       gnt_d, gnt_i, gnt_pf, any_gnt;
  logic       is_load, alloc, complete, accepted;
  logic [1:0] gnt_src, done_src;

  assign under_limit = int'(cnt_q) < MAX_OUTSTANDING;
  assign gnt_d       = dcache_cmd != 2'd0;
  assign gnt_i       = !gnt_d && icache_req;
  assign gnt_pf      = !gnt_d && !icache_req && pf_req && under_limit;
  assign any_gnt     = gnt_d || gnt_i || gnt_pf;
  assign is_load     = gnt_d ? (dcache_cmd == CMD_LOAD) : (gnt_i || gnt_pf);
  assign accepted    = any_gnt && (mem2proc_response != 4'd0);
  assign alloc       = !reset && is_load && (mem2proc_response != 4'd0);
  assign complete    = !reset && (mem2proc_tag != 4'd0) && valid_q[mem2proc_tag];
  assign gnt_src     = gnt_d ? SRC_D : (gnt_i ? SRC_I : SRC_PF);
  assign done_src    = src_q[mem2proc_tag];
  assign done_data   = mem2proc_data;

  always_comb begin
    proc2mem_command = 2'd0;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    dcache_resp_tag  = 4'd0;
    icache_resp_tag  = 4'd0;
    pf_resp_tag      = 4'd0;
    dcache_done      = 1'b0;
    icache_done      = 1'b0;
    pf_done          = 1'b0;
    done_tag         = 4'd0;
    outstanding_cnt  = 4'd0;
    if (!reset) begin
      outstanding_cnt = cnt_q;
      if (gnt_d) begin
        proc2mem_command = dcache_cmd;
        proc2mem_addr    = dcache_addr;
        dcache_resp_tag  = mem2proc_response;
        if (dcache_cmd == CMD_STORE) proc2mem_data = dcache_data;
      end else if (gnt_i) begin
        proc2mem_command = CMD_LOAD;
        proc2mem_addr    = icache_addr;
        icache_resp_tag  = mem2proc_response;
      end else if (gnt_pf) begin
        proc2mem_command = CMD_LOAD;
        proc2mem_addr    = pf_addr;
        pf_resp_tag      = mem2proc_response;
      end
      // The done pulse follows the source recorded before any same-cycle reallocation.
      if (complete) begin
        done_tag    = mem2proc_tag;
        dcache_done = done_src == SRC_D;
        icache_done = done_src == SRC_I;
        pf_done     = done_src == SRC_PF;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      cnt_q   <= 4'd0;
    end else begin
      if (complete) valid_q[mem2proc_tag] <= 1'b0;
      if (alloc) begin
        valid_q[mem2proc_response] <= 1'b1;
        src_q[mem2proc_response]   <= gnt_src;
      end
      case ({alloc, complete})
        2'b10:   if (cnt_q != 4'd15) cnt_q <= cnt_q + 4'd1;
        2'b01:   if (cnt_q != 4'd0)  cnt_q <= cnt_q - 4'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_grant_d  <= 16'd0;
      stat_grant_i  <= 16'd0;
      stat_grant_pf <= 16'd0;
      stat_reject   <= 16'd0;
      stat_throttle <= 16'd0;
    end else begin
      if (accepted && gnt_d && stat_grant_d != 16'hFFFF)   stat_grant_d  <= stat_grant_d + 16'd1;
      if (accepted && gnt_i && stat_grant_i != 16'hFFFF)   stat_grant_i  <= stat_grant_i + 16'd1;
      if (accepted && gnt_pf && stat_grant_pf != 16'hFFFF) stat_grant_pf <= stat_grant_pf + 16'd1;
      if (any_gnt && !accepted && stat_reject != 16'hFFFF) stat_reject   <= stat_reject + 16'd1;
      if (pf_req && !under_limit && stat_throttle != 16'hFFFF)
        stat_throttle <= stat_throttle + 16'd1;
    end
  end
`else
  logic unused_accepted;
  assign unused_accepted = accepted;
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - scoreboard bench for mem_req_arbiter (MAX_OUTSTANDING = 2)
module tb_mem_req_arbiter;

  localparam int MAXO = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  dcache_cmd;
  logic [31:0] dcache_addr, icache_addr, pf_addr, proc2mem_addr;
  logic [63:0] dcache_data, mem2proc_data, proc2mem_data, done_data;
  logic        icache_req, pf_req;
  logic [3:0]  mem2proc_response, mem2proc_tag;
  logic [1:0]  proc2mem_command;
  logic [3:0]  dcache_resp_tag, icache_resp_tag, pf_resp_tag, done_tag, outstanding_cnt;
  logic        dcache_done, icache_done, pf_done;
`ifdef ARB_STATS_EN
  logic [15:0] stat_grant_d, stat_grant_i, stat_grant_pf, stat_reject, stat_throttle;
`endif

  mem_req_arbiter #(.MAX_OUTSTANDING(MAXO), .ADDR_W(32), .DATA_W(64)) dut (
    .clock(clock), .reset(reset),
    .dcache_cmd(dcache_cmd), .dcache_addr(dcache_addr), .dcache_data(dcache_data),
    .icache_req(icache_req), .icache_addr(icache_addr),
    .pf_req(pf_req), .pf_addr(pf_addr),
    .mem2proc_response(mem2proc_response), .mem2proc_tag(mem2proc_tag),
    .mem2proc_data(mem2proc_data),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data),
    .dcache_resp_tag(dcache_resp_tag), .icache_resp_tag(icache_resp_tag),
    .pf_resp_tag(pf_resp_tag),
    .dcache_done(dcache_done), .icache_done(icache_done), .pf_done(pf_done),
    .done_tag(done_tag), .done_data(done_data), .outstanding_cnt(outstanding_cnt)
`ifdef ARB_STATS_EN
    , .stat_grant_d(stat_grant_d), .stat_grant_i(stat_grant_i), .stat_grant_pf(stat_grant_pf),
    .stat_reject(stat_reject), .stat_throttle(stat_throttle)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] tag;
    logic [1:0] src;
  } sb_ent_t;

  sb_ent_t sb[$];
  int      exp_cnt = 0;
  int      checks  = 0;
  int      errors  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_sb(input logic [3:0] t);
    foreach (sb[k]) if (sb[k].tag == t) return 1'b1;
    return 1'b0;
  endfunction

  // One cycle: drive, check outputs mid-cycle against the scoreboard, update it, advance.
  task automatic apply(input logic rst, input logic [1:0] dc, input logic [31:0] da,
                       input logic [63:0] dd, input logic ir, input logic [31:0] ia,
                       input logic pr, input logic [31:0] pa, input logic [3:0] rsp,
                       input logic [3:0] ct, input logic [63:0] cd);
    int         g, idx;
    logic [1:0] ecmd;
    logic [31:0] eaddr;
    logic [63:0] edata;
    logic [3:0] erd, eri, erp, etag;
    logic [2:0] edone;
    reset = rst; dcache_cmd = dc; dcache_addr = da; dcache_data = dd;
    icache_req = ir; icache_addr = ia; pf_req = pr; pf_addr = pa;
    mem2proc_response = rsp; mem2proc_tag = ct; mem2proc_data = cd;
    #4;
    g = 0; idx = -1; ecmd = 0; eaddr = 0; edata = 0; erd = 0; eri = 0; erp = 0;
    etag = 0; edone = 0;
    if (!rst) begin
      if (dc != 0) g = 1;
      else if (ir) g = 2;
      else if (pr && exp_cnt < MAXO) g = 3;
      case (g)
        1: begin ecmd = dc; eaddr = da; erd = rsp; if (dc == 2) edata = dd; end
        2: begin ecmd = 1; eaddr = ia; eri = rsp; end
        3: begin ecmd = 1; eaddr = pa; erp = rsp; end
        default: ;
      endcase
      if (ct != 0) foreach (sb[k]) if (sb[k].tag == ct) idx = k;
      if (idx >= 0) begin
        edone[sb[idx].src] = 1'b1;
        etag = ct;
      end
    end
    check("command", 64'(proc2mem_command), 64'(ecmd));
    check("addr", 64'(proc2mem_addr), 64'(eaddr));
    check("wdata", proc2mem_data, edata);
    check("d_resp", 64'(dcache_resp_tag), 64'(erd));
    check("i_resp", 64'(icache_resp_tag), 64'(eri));
    check("pf_resp", 64'(pf_resp_tag), 64'(erp));
    check("dones", 64'({pf_done, icache_done, dcache_done}), 64'(edone));
    check("done_tag", 64'(done_tag), 64'(etag));
    check("done_data", done_data, cd);
    check("cnt", 64'(outstanding_cnt), rst ? 64'd0 : 64'(exp_cnt));
    if (rst) begin
      sb.delete();
      exp_cnt = 0;
    end else begin
      if (idx >= 0) begin
        sb.delete(idx);
        exp_cnt--;
      end
      if (rsp != 0 && (g == 2 || g == 3 || (g == 1 && dc == 1))) begin
        sb.push_back('{tag: rsp, src: (g == 1) ? 2'd0 : (g == 2) ? 2'd1 : 2'd2});
        exp_cnt++;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input logic [3:0] ct, input logic [63:0] cd);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, ct, cd);
  endtask

  initial begin
    // Reset with every requester active
    apply(1, 1, 32'h100, 64'h1, 1, 32'h200, 1, 32'h208, 4'd3, 4'd3, 64'h11);
    apply(1, 1, 32'h100, 64'h1, 1, 32'h200, 1, 32'h208, 4'd3, 4'd3, 64'h22);

    // D wins over I and PF; completion routed to D
    apply(0, 1, 32'h100, 64'h0, 1, 32'h200, 1, 32'h208, 4'd3, 4'd0, 64'h0);
    idle(4'd3, 64'hDEAD);

    // Rejected I grant then accepted retry
    apply(0, 0, 0, 0, 1, 32'h40, 1, 32'h48, 4'd0, 4'd0, 64'h0);
    apply(0, 0, 0, 0, 1, 32'h40, 1, 32'h48, 4'd5, 4'd0, 64'h0);
    idle(4'd5, 64'h55);

    // PF throttled once count reaches the limit; I still granted
    apply(0, 0, 0, 0, 0, 0, 1, 32'h80, 4'd1, 4'd0, 64'h0);
    apply(0, 0, 0, 0, 0, 0, 1, 32'h88, 4'd2, 4'd0, 64'h0);
    apply(0, 0, 0, 0, 0, 0, 1, 32'h90, 4'd7, 4'd0, 64'h0);
    apply(0, 0, 0, 0, 1, 32'h400, 1, 32'h90, 4'd7, 4'd0, 64'h0);
    idle(4'd1, 64'h1);
    idle(4'd2, 64'h2);
    idle(4'd7, 64'h7);

    // Same-cycle complete and reallocate of tag 4
    apply(0, 0, 0, 0, 0, 0, 1, 32'hA0, 4'd4, 4'd0, 64'h0);
    apply(0, 0, 0, 0, 1, 32'hB0, 0, 0, 4'd4, 4'd4, 64'h44);
    idle(4'd4, 64'h4444);

    // Accepted store is not tracked; unknown tag completes to nothing
    apply(0, 2, 32'h300, 64'hCAFE, 0, 0, 0, 0, 4'd6, 4'd0, 64'h0);
    idle(4'd6, 64'h66);
    idle(4'd9, 64'h99);

    // In-flight tag dropped by mid-operation reset
    apply(0, 0, 0, 0, 1, 32'hC0, 0, 0, 4'd8, 4'd0, 64'h0);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0, 64'h0);
    idle(4'd8, 64'h88);

    // Randomised traffic with unique live tags
    for (int n = 0; n < 60; n++) begin
      logic [1:0] dc;
      logic [3:0] rsp, ct;
      dc  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
      rsp = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      if (sb.size() != 0 && $urandom_range(0, 1) == 1)
        ct = sb[$urandom_range(0, sb.size() - 1)].tag;
      else
        ct = 4'($urandom_range(0, 15));
      if (rsp != 0 && in_sb(rsp) && rsp != ct) rsp = 4'd0;
      apply(0, dc, $urandom, {$urandom, $urandom}, 1'($urandom_range(0, 1)), $urandom,
            1'($urandom_range(0, 1)), $urandom, rsp, ct, {$urandom, $urandom});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
